maxpool_channel_scheduler: RTL and testbench

Sequencer that time-shares one single-channel max-pool unit (W inputs in, W/2 outputs out, combinational, instantiated outside this block) across K channels. On a start request it feeds channel slices 0..K-1 to the shared unit one per cycle. It captures each pooled result one cycle later into the correct output slot, with no slot skipped and no out-of-range slot written, then raises done. It sits between the conv layer output buffer and the next layer's input.

---
 rtl/maxpool_channel_scheduler_pkg.sv | 32 +++
 rtl/maxpool_channel_scheduler_if.sv | 30 +++
 rtl/maxpool_channel_scheduler.sv | 95 +++++++++
 tb/tb_maxpool_channel_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_channel_scheduler_pkg.sv
// rtl/maxpool_channel_scheduler_pkg.sv - shared types and slice-offset helpers for the max-pool channel scheduler
package maxpool_channel_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Bit offset of channel c inside the packed K-channel input bus.
  function automatic int in_offset(input int c, input int w, input int dw);
    return c * w * dw;
  endfunction

  // Bit offset of channel c inside the packed K-channel pooled output bus.
  function automatic int out_offset(input int c, input int w, input int dw);
    return c * (w / 2) * dw;
  endfunction

endpackage

// File: rtl/maxpool_channel_scheduler_if.sv
// rtl/maxpool_channel_scheduler_if.sv - job, data and shared-unit signals of the max-pool channel scheduler
interface maxpool_channel_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int K          = 4,
  parameter int W          = 128
);
  import maxpool_channel_scheduler_pkg::*;

  localparam int CW = clog2(K + 1);

  logic                              start;
  logic [W*K*DATA_WIDTH-1:0]         in_data;
  logic [W*DATA_WIDTH-1:0]           mp_in;
  logic [(W/2)*DATA_WIDTH-1:0]       mp_out;
  logic [(W/2)*K*DATA_WIDTH-1:0]     out_data;
  logic [CW-1:0]                     ch_idx;
  logic                              busy;
  logic                              done;

  modport master (
    output start, in_data, mp_out,
    input  mp_in, out_data, ch_idx, busy, done
  );

  modport slave (
    input  start, in_data, mp_out,
    output mp_in, out_data, ch_idx, busy, done
  );

endinterface

// File: rtl/maxpool_channel_scheduler.sv
// rtl/maxpool_channel_scheduler.sv - time-shares one single-channel max-pool unit across K channels
module maxpool_channel_scheduler
  import maxpool_channel_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int K          = 4,
  parameter int W          = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  maxpool_channel_scheduler_if.slave   bus
);

  localparam int CW = clog2(K + 1);
  localparam int SW = W * DATA_WIDTH;
  localparam int OW = (W / 2) * DATA_WIDTH;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       issue;
  logic [SW-1:0]       mp_in_q;
  logic [OW*K-1:0]     out_q;
  logic [CW-1:0]       ch_q;
  logic                busy_q;
  logic                done_q;
  logic                accept;
  logic                last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (issue >= CW'(K)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // issue counts slices already on mp_in, so slot issue-1 is the one whose
  // pooled result is present on mp_out during this RUN cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue   <= '0;
      mp_in_q <= '0;
      out_q   <= '0;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (accept) begin
      mp_in_q <= bus.in_data[in_offset(0, W, DATA_WIDTH) +: SW];
      ch_q    <= '0;
      issue   <= CW'(1);
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (state == RUN) begin
      if (issue != '0 && issue <= CW'(K)) begin
        out_q[out_offset(int'(issue) - 1, W, DATA_WIDTH) +: OW] <= bus.mp_out;
      end
      if (last) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        mp_in_q <= bus.in_data[in_offset(int'(issue), W, DATA_WIDTH) +: SW];
        ch_q    <= issue;
        issue   <= issue + CW'(1);
      end
    end
  end

  assign bus.mp_in    = mp_in_q;
  assign bus.out_data = out_q;
  assign bus.ch_idx   = ch_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_maxpool_channel_scheduler.sv
// tb/tb_maxpool_channel_scheduler.sv - self-checking bench for the max-pool channel scheduler
module tb_maxpool_channel_scheduler;

  localparam int DW    = 16;
  localparam int K     = 4;
  localparam int W     = 8;
  localparam int SW    = W * DW;
  localparam int OW    = (W / 2) * DW;
  localparam int IN_W  = K * SW;
  localparam int NV    = 3;

  typedef struct packed {
    logic [K-1:0][W-1:0][DW-1:0]   smp;
    logic [K-1:0][W/2-1:0][DW-1:0] exp_out;
  } vec_t;

  logic clk;
  logic reset;

  maxpool_channel_scheduler_if #(.DATA_WIDTH(DW), .K(K), .W(W)) bus ();

  maxpool_channel_scheduler #(.DATA_WIDTH(DW), .K(K), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests_run;
  int tests_failed;
  int smp[K][W];
  int model_out[K][W/2];
  vec_t table_v[NV];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] pool_fn(input logic [SW-1:0] v);
    logic [OW-1:0] r;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    r = '0;
    for (int j = 0; j < W / 2; j++) begin
      a = v[(W - 1 - 2 * j) * DW +: DW];
      b = v[(W - 2 - 2 * j) * DW +: DW];
      r[(W / 2 - 1 - j) * DW +: DW] = (a > b) ? a : b;
    end
    return r;
  endfunction

  assign bus.mp_out = pool_fn(bus.mp_in);

  function automatic logic [IN_W-1:0] pack_in();
    logic [IN_W-1:0] v;
    v = '0;
    for (int c = 0; c < K; c++)
      for (int s = 0; s < W; s++)
        v[c * SW + (W - 1 - s) * DW +: DW] = 16'(smp[c][s]);
    return v;
  endfunction

  function automatic void model_job();
    for (int c = 0; c < K; c++)
      for (int j = 0; j < W / 2; j++)
        model_out[c][j] = (smp[c][2*j] > smp[c][2*j+1]) ? smp[c][2*j] : smp[c][2*j+1];
  endfunction

  function automatic void random_smp();
    for (int c = 0; c < K; c++)
      for (int s = 0; s < W; s++)
        smp[c][s] = int'($signed(16'($urandom)));
  endfunction

  function automatic logic signed [DW-1:0] out_smp(input int c, input int j);
    return $signed(bus.out_data[c * OW + (W / 2 - 1 - j) * DW +: DW]);
  endfunction

  function automatic logic signed [DW-1:0] mp_in_smp(input int s);
    return $signed(bus.mp_in[(W - 1 - s) * DW +: DW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    for (int c = 0; c < K; c++)
      for (int j = 0; j < W / 2; j++)
        chk($sformatf("%s out c%0d j%0d", tag, c, j), out_smp(c, j), model_out[c][j]);
  endtask

  // Drives one job from smp; tick n lands just after edge T0+n-1.
  task automatic run_job(input string tag, input bit noise);
    bus.in_data = pack_in();
    bus.start = 1'b1;
    for (int n = 1; n <= K + 1; n++) begin
      tick();
      bus.start = noise && (n <= 2);
      if (n <= K) begin
        chk($sformatf("%s busy n%0d", tag, n), bus.busy, 1);
        chk($sformatf("%s done n%0d", tag, n), bus.done, 0);
        chk($sformatf("%s ch_idx n%0d", tag, n), bus.ch_idx, n - 1);
        chk($sformatf("%s mp_in s0 n%0d", tag, n), mp_in_smp(0), smp[n-1][0]);
        chk($sformatf("%s mp_in s%0d n%0d", tag, W - 1, n), mp_in_smp(W - 1), smp[n-1][W-1]);
      end else begin
        chk($sformatf("%s done at T0+K", tag), bus.done, 1);
        chk($sformatf("%s busy at T0+K", tag), bus.busy, 0);
        chk($sformatf("%s ch_idx hold", tag), bus.ch_idx, K - 1);
      end
    end
    bus.start = 1'b0;
    model_job();
    check_out(tag);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    bus.start = 1'b1;
    bus.in_data = '0;
    for (int c = 0; c < K; c++)
      for (int j = 0; j < W / 2; j++)
        model_out[c][j] = 0;

    for (int c = 0; c < K; c++) begin
      for (int s = 0; s < W; s++) begin
        table_v[0].smp[c][s] = 16'(c * 10 + s);
        table_v[1].smp[c][s] = 16'(c * 10 + s);
      end
      for (int j = 0; j < W / 2; j++) begin
        table_v[0].exp_out[c][j] = 16'(c * 10 + 2 * j + 1);
        table_v[1].exp_out[c][j] = 16'(c * 10 + 2 * j + 1);
      end
      table_v[2].smp[c] = {16'sh8000, 16'sh7fff, -16'sd1, 16'sd0, 16'(c), 16'(-c), 16'sd100, 16'sd100};
      table_v[2].exp_out[c] = {16'sh7fff, 16'sd0, 16'(c), 16'sd100};
    end
    table_v[1].smp[2] = {16'sd7, 16'sd6, -16'sd1, 16'sd0, -16'sd9, -16'sd8, -16'sd3, -16'sd5};
    table_v[1].exp_out[2] = {16'sd7, 16'sd0, -16'sd8, -16'sd3};

    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("reset busy %0d", n), bus.busy, 0);
      chk($sformatf("reset done %0d", n), bus.done, 0);
      chk($sformatf("reset out_data zero %0d", n), bus.out_data == '0, 1);
      chk($sformatf("reset mp_in zero %0d", n), bus.mp_in == '0, 1);
      chk($sformatf("reset ch_idx %0d", n), bus.ch_idx, 0);
    end
    bus.start = 1'b0;
    reset = 1'b1;
    tick();
    chk("idle busy", bus.busy, 0);

    for (int v = 0; v < NV; v++) begin
      for (int c = 0; c < K; c++)
        for (int s = 0; s < W; s++)
          smp[c][s] = int'($signed(table_v[v].smp[c][s]));
      run_job($sformatf("vec%0d", v), v == 0);
      for (int c = 0; c < K; c++)
        for (int j = 0; j < W / 2; j++)
          chk($sformatf("vec%0d table c%0d j%0d", v, c, j), out_smp(c, j), $signed(table_v[v].exp_out[c][j]));
      if (v == 0) begin
        for (int n = 0; n < 2; n++) begin
          tick();
          chk($sformatf("no queued job done %0d", n), bus.done, 1);
          chk($sformatf("no queued job busy %0d", n), bus.busy, 0);
        end
      end
    end

    random_smp();
    bus.in_data = pack_in();
    model_job();
    bus.start = 1'b1;
    for (int n = 1; n <= 2 * K + 2; n++) begin
      tick();
      if (n == K + 1) begin
        chk("b2b first done", bus.done, 1);
        check_out("b2b first");
        random_smp();
        bus.in_data = pack_in();
        model_job();
      end else if (n == K + 2) begin
        chk("b2b done drops", bus.done, 0);
        chk("b2b busy again", bus.busy, 1);
        chk("b2b ch_idx restart", bus.ch_idx, 0);
      end else if (n == 2 * K + 1) begin
        chk("b2b not yet done", bus.done, 0);
      end else if (n == 2 * K + 2) begin
        chk("b2b second done", bus.done, 1);
        check_out("b2b second");
      end
    end
    bus.start = 1'b0;
    tick();

    random_smp();
    bus.in_data = pack_in();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("midrst busy", bus.busy, 0);
    chk("midrst done", bus.done, 0);
    chk("midrst out_data zero", bus.out_data == '0, 1);
    chk("midrst mp_in zero", bus.mp_in == '0, 1);
    chk("midrst ch_idx", bus.ch_idx, 0);
    reset = 1'b1;
    tick();
    chk("post reset idle busy", bus.busy, 0);
    chk("post reset idle done", bus.done, 0);
    run_job("after reset", 1'b0);

    for (int r = 0; r < 12; r++) begin
      random_smp();
      run_job($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        chk($sformatf("rnd%0d gap done hold", r), bus.done, 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
